// File: rtl/regfile_pkg.sv
// Shared types and constants for the 2-read/1-write register file.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package regfile_pkg;

    // Width of one byte lane covered by a single write-enable bit.
    localparam int BYTE_W = 8;

    // Controller states: normal operation, or sweeping every word to zero.
    typedef enum logic [0:0] {
        READY = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/rf_word.sv
// One byte-enabled storage word with async reset and synchronous clear.
// Latency: write visible on q one cycle after the sampling edge.
// Backpressure: none; clr takes priority over wr_en.
//
// Ports:
//   clk, reset_n       - clock and async active-low reset (zeroes the word)
//   clr                - synchronous zero of the whole word
//   wr_en, wr_be, wr_data - byte-masked write
//   q                  - current stored value
module rf_word
    import regfile_pkg::*;
#(
    parameter int WORD_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clr,
    input  logic                         wr_en,
    input  logic [WORD_WIDTH/BYTE_W-1:0] wr_be,
    input  logic [WORD_WIDTH-1:0]        wr_data,
    output logic [WORD_WIDTH-1:0]        q
);

    localparam int NB = WORD_WIDTH / BYTE_W;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_be[b]) begin
                    q[b*BYTE_W +: BYTE_W] <= wr_data[b*BYTE_W +: BYTE_W];
                end
            end
        end
    end

endmodule

// File: rtl/regfile_2r1w.sv
// Register file, two independent read ports, one byte-masked write port, sweep clear.
// Latency: reads return registered data one cycle after sampling (write-first on collision).
// Backpressure: busy high for LENGTH cycles during clear; requests in that window are dropped.
//
// Ports:
//   clk, reset_n                      - clock and async active-low reset
//   wr_en, wr_addr, wr_be, wr_data    - write request with byte enables
//   rd_en_x, rd_addr_x                - read request, ports A and B
//   rd_data_x, rd_valid_x             - registered read data and one-cycle valid pulse
//   clear_req, busy                   - start a zeroing sweep; high while sweeping
//   addr_err                          - one-cycle pulse after any out-of-range access
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int LENGTH     = 128,
    parameter int AW         = $clog2(LENGTH)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         wr_en,
    input  logic [AW-1:0]                wr_addr,
    input  logic [WORD_WIDTH/BYTE_W-1:0] wr_be,
    input  logic [WORD_WIDTH-1:0]        wr_data,
    input  logic                         rd_en_a,
    input  logic                         rd_en_b,
    input  logic [AW-1:0]                rd_addr_a,
    input  logic [AW-1:0]                rd_addr_b,
    output logic [WORD_WIDTH-1:0]        rd_data_a,
    output logic [WORD_WIDTH-1:0]        rd_data_b,
    output logic                         rd_valid_a,
    output logic                         rd_valid_b,
    input  logic                         clear_req,
    output logic                         busy,
    output logic                         addr_err
);

    localparam int            NB    = WORD_WIDTH / BYTE_W;
    // One extra bit so LENGTH itself is representable when it is a power of two.
    localparam logic [AW:0]   LEN_V = (AW+1)'(LENGTH);
    localparam logic [AW-1:0] LAST  = AW'(LENGTH - 1);

    state_t                  state;
    logic [AW-1:0]           sweep;
    logic [WORD_WIDTH-1:0]   words [LENGTH];

    logic ready;
    logic wr_in, ra_in, rb_in;
    logic do_write;
    logic [WORD_WIDTH-1:0] fwd_a, fwd_b;

    assign ready = (state == READY);
    assign busy  = (state == CLEAR);
    assign wr_in = {1'b0, wr_addr}   < LEN_V;
    assign ra_in = {1'b0, rd_addr_a} < LEN_V;
    assign rb_in = {1'b0, rd_addr_b} < LEN_V;

    // A clear request in the same cycle drops the write.
    assign do_write = ready && wr_en && wr_in && !clear_req;

    // Overlay the in-flight write onto a stored word so a colliding read sees new bytes.
    function automatic logic [WORD_WIDTH-1:0] merge_bytes(
        input logic [WORD_WIDTH-1:0] old_w,
        input logic [WORD_WIDTH-1:0] new_w,
        input logic [NB-1:0]         be
    );
        logic [WORD_WIDTH-1:0] r;
        r = old_w;
        for (int b = 0; b < NB; b++) begin
            if (be[b]) begin
                r[b*BYTE_W +: BYTE_W] = new_w[b*BYTE_W +: BYTE_W];
            end
        end
        return r;
    endfunction

    // Out-of-range reads yield zero.
    always_comb begin
        fwd_a = '0;
        if (ra_in) begin
            fwd_a = words[rd_addr_a];
            if (do_write && (wr_addr == rd_addr_a)) begin
                fwd_a = merge_bytes(words[rd_addr_a], wr_data, wr_be);
            end
        end
    end

    always_comb begin
        fwd_b = '0;
        if (rb_in) begin
            fwd_b = words[rd_addr_b];
            if (do_write && (wr_addr == rd_addr_b)) begin
                fwd_b = merge_bytes(words[rd_addr_b], wr_data, wr_be);
            end
        end
    end

    for (genvar i = 0; i < LENGTH; i++) begin : g_word
        rf_word #(
            .WORD_WIDTH (WORD_WIDTH)
        ) u_word (
            .clk     (clk),
            .reset_n (reset_n),
            .clr     (busy && (sweep == AW'(i))),
            .wr_en   (do_write && (wr_addr == AW'(i))),
            .wr_be   (wr_be),
            .wr_data (wr_data),
            .q       (words[i])
        );
    end

    // Sweep controller: clear_req is only honoured from READY, so a request
    // mid-sweep cannot restart the counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= READY;
            sweep <= '0;
        end else begin
            case (state)
                READY: begin
                    if (clear_req) begin
                        state <= CLEAR;
                        sweep <= '0;
                    end
                end
                CLEAR: begin
                    if (sweep == LAST) begin
                        state <= READY;
                        sweep <= '0;
                    end else begin
                        sweep <= sweep + AW'(1);
                    end
                end
                default: begin
                    state <= READY;
                    sweep <= '0;
                end
            endcase
        end
    end

    // Read data holds between valid pulses. Reads sampled alongside clear_req
    // still complete, since the state is READY in that cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_a  <= '0;
            rd_data_b  <= '0;
            rd_valid_a <= 1'b0;
            rd_valid_b <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            rd_valid_a <= ready && rd_en_a;
            rd_valid_b <= ready && rd_en_b;
            if (ready && rd_en_a) begin
                rd_data_a <= fwd_a;
            end
            if (ready && rd_en_b) begin
                rd_data_b <= fwd_b;
            end
            addr_err <= ready && ((wr_en && !wr_in && !clear_req) ||
                                  (rd_en_a && !ra_in) ||
                                  (rd_en_b && !rb_in));
        end
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed self-checking bench for regfile_2r1w (128-word and 100-word instances).
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled 1 unit after the next.
// Backpressure: clear sweep bounded by a cycle budget.
module tb_regfile_2r1w;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    // 128-word instance
    logic        wr_en = 1'b0;
    logic [6:0]  wr_addr = '0;
    logic [3:0]  wr_be = '0;
    logic [31:0] wr_data = '0;
    logic        rd_en_a = 1'b0, rd_en_b = 1'b0;
    logic [6:0]  rd_addr_a = '0, rd_addr_b = '0;
    logic [31:0] rd_data_a, rd_data_b;
    logic        rd_valid_a, rd_valid_b;
    logic        clear_req = 1'b0;
    logic        busy, addr_err;

    // 100-word instance
    logic        s_wr_en = 1'b0;
    logic [6:0]  s_wr_addr = '0;
    logic [3:0]  s_wr_be = '0;
    logic [31:0] s_wr_data = '0;
    logic        s_rd_en_a = 1'b0, s_rd_en_b = 1'b0;
    logic [6:0]  s_rd_addr_a = '0, s_rd_addr_b = '0;
    logic [31:0] s_rd_data_a, s_rd_data_b;
    logic        s_rd_valid_a, s_rd_valid_b;
    logic        s_clear_req = 1'b0;
    logic        s_busy, s_addr_err;

    int checks = 0;
    int fails  = 0;

    regfile_2r1w #(.WORD_WIDTH(32), .LENGTH(128)) dut (
        .clk(clk), .reset_n(reset_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en_a(rd_en_a), .rd_en_b(rd_en_b),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .rd_valid_a(rd_valid_a), .rd_valid_b(rd_valid_b),
        .clear_req(clear_req), .busy(busy), .addr_err(addr_err)
    );

    regfile_2r1w #(.WORD_WIDTH(32), .LENGTH(100)) dut100 (
        .clk(clk), .reset_n(reset_n),
        .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_be(s_wr_be), .wr_data(s_wr_data),
        .rd_en_a(s_rd_en_a), .rd_en_b(s_rd_en_b),
        .rd_addr_a(s_rd_addr_a), .rd_addr_b(s_rd_addr_b),
        .rd_data_a(s_rd_data_a), .rd_data_b(s_rd_data_b),
        .rd_valid_a(s_rd_valid_a), .rd_valid_b(s_rd_valid_b),
        .clear_req(s_clear_req), .busy(s_busy), .addr_err(s_addr_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [6:0] a, input logic [3:0] be, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_be = be; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_read_a(input logic [6:0] a, output logic [31:0] d, output logic v);
        rd_en_a = 1'b1; rd_addr_a = a;
        tick();
        rd_en_a = 1'b0;
        d = rd_data_a;
        v = rd_valid_a;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++; if (rd_data_a !== 32'h0 || rd_data_b !== 32'h0) begin fails++; $display("FAIL reset_rd_data a=%h b=%h want 0", rd_data_a, rd_data_b); end
        checks++; if (rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0) begin fails++; $display("FAIL reset_rd_valid a=%b b=%b want 0", rd_valid_a, rd_valid_b); end
        checks++; if (busy !== 1'b0 || addr_err !== 1'b0) begin fails++; $display("FAIL reset_busy_err busy=%b err=%b want 0", busy, addr_err); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        logic [31:0] d; logic v;
        do_write(7'd5, 4'hF, 32'hDEADBEEF);
        do_read_a(7'd5, d, v);
        checks++; if (d !== 32'hDEADBEEF || v !== 1'b1) begin fails++; $display("FAIL wr_rd_5 data=%h valid=%b want deadbeef/1", d, v); end
        tick();
        checks++; if (rd_valid_a !== 1'b0 || rd_data_a !== 32'hDEADBEEF) begin fails++; $display("FAIL hold_a valid=%b data=%h want 0/deadbeef", rd_valid_a, rd_data_a); end
    endtask

    task automatic test_write_first();
        logic [31:0] d; logic v;
        do_write(7'd7, 4'hF, 32'h11223344);
        wr_en = 1'b1; wr_addr = 7'd7; wr_be = 4'h5; wr_data = 32'hAABBCCDD;
        rd_en_b = 1'b1; rd_addr_b = 7'd7;
        tick();
        wr_en = 1'b0; rd_en_b = 1'b0;
        checks++; if (rd_data_b !== 32'h11BB33DD || rd_valid_b !== 1'b1) begin fails++; $display("FAIL write_first_b data=%h valid=%b want 11bb33dd/1", rd_data_b, rd_valid_b); end
        // all-zero byte enables: no change, no error
        do_write(7'd7, 4'h0, 32'hFFFFFFFF);
        checks++; if (addr_err !== 1'b0) begin fails++; $display("FAIL be0_err err=%b want 0", addr_err); end
        do_read_a(7'd7, d, v);
        checks++; if (d !== 32'h11BB33DD) begin fails++; $display("FAIL be0_keep data=%h want 11bb33dd", d); end
    endtask

    task automatic test_dual_port();
        do_write(7'd9,  4'hF, 32'h09090909);
        do_write(7'd10, 4'hF, 32'h0A0A0A0A);
        rd_en_a = 1'b1; rd_en_b = 1'b1; rd_addr_a = 7'd9; rd_addr_b = 7'd9;
        tick();
        checks++; if (rd_data_a !== 32'h09090909 || rd_data_b !== 32'h09090909 || !rd_valid_a || !rd_valid_b) begin
            fails++; $display("FAIL same_addr a=%h b=%h va=%b vb=%b want 09090909 both", rd_data_a, rd_data_b, rd_valid_a, rd_valid_b); end
        rd_addr_b = 7'd10;
        tick();
        rd_en_a = 1'b0; rd_en_b = 1'b0;
        checks++; if (rd_data_a !== 32'h09090909 || rd_data_b !== 32'h0A0A0A0A || !rd_valid_a || !rd_valid_b) begin
            fails++; $display("FAIL diff_addr a=%h b=%h want 09090909/0a0a0a0a", rd_data_a, rd_data_b); end
    endtask

    task automatic test_out_of_range();
        s_wr_en = 1'b1; s_wr_addr = 7'd20; s_wr_be = 4'hF; s_wr_data = 32'h12345678;
        tick();
        s_wr_en = 1'b0;
        s_rd_en_a = 1'b1; s_rd_addr_a = 7'd20;
        tick();
        s_rd_en_a = 1'b0;
        checks++; if (s_rd_data_a !== 32'h12345678 || s_addr_err !== 1'b0) begin fails++; $display("FAIL oor_pre data=%h err=%b want 12345678/0", s_rd_data_a, s_addr_err); end
        s_wr_en = 1'b1; s_wr_addr = 7'd120; s_wr_data = 32'hFFFFFFFF;
        tick();
        s_wr_en = 1'b0;
        checks++; if (s_addr_err !== 1'b1) begin fails++; $display("FAIL oor_wr_err err=%b want 1", s_addr_err); end
        tick();
        checks++; if (s_addr_err !== 1'b0) begin fails++; $display("FAIL oor_wr_pulse err=%b want 0", s_addr_err); end
        s_rd_en_a = 1'b1; s_rd_addr_a = 7'd120;
        tick();
        s_rd_en_a = 1'b0;
        checks++; if (s_rd_data_a !== 32'h0 || s_rd_valid_a !== 1'b1 || s_addr_err !== 1'b1) begin
            fails++; $display("FAIL oor_rd data=%h valid=%b err=%b want 0/1/1", s_rd_data_a, s_rd_valid_a, s_addr_err); end
        tick();
        checks++; if (s_addr_err !== 1'b0) begin fails++; $display("FAIL oor_rd_pulse err=%b want 0", s_addr_err); end
        s_rd_en_a = 1'b1; s_rd_addr_a = 7'd20;
        tick();
        s_rd_en_a = 1'b0;
        checks++; if (s_rd_data_a !== 32'h12345678) begin fails++; $display("FAIL oor_no_corrupt data=%h want 12345678", s_rd_data_a); end
    endtask

    task automatic test_clear();
        logic [31:0] d; logic v;
        int cnt, stray, nonzero;
        for (int i = 0; i < 128; i++) begin
            logic [7:0] bt;
            bt = 8'(i + 1);
            do_write(7'(i), 4'hF, {4{bt}});
        end
        do_read_a(7'd100, d, v);
        checks++; if (d !== 32'h65656565) begin fails++; $display("FAIL fill_100 data=%h want 65656565", d); end
        clear_req = 1'b1;
        wr_en = 1'b1; wr_addr = 7'd3; wr_be = 4'hF; wr_data = 32'hFFFFFFFF;
        rd_en_a = 1'b1; rd_addr_a = 7'd4;
        tick();
        clear_req = 1'b0;
        checks++; if (rd_valid_a !== 1'b1 || rd_data_a !== 32'h05050505 || busy !== 1'b1) begin
            fails++; $display("FAIL clear_start valid=%b data=%h busy=%b want 1/05050505/1", rd_valid_a, rd_data_a, busy); end
        // keep requesting during the sweep; none may take effect
        wr_addr = 7'd5; wr_data = 32'hEEEEEEEE; rd_addr_a = 7'd1;
        rd_en_b = 1'b1; rd_addr_b = 7'd2;
        cnt = 1; stray = 0;
        for (int k = 0; k < 300 && busy; k++) begin
            clear_req = (cnt == 60);
            tick();
            if (rd_valid_a || rd_valid_b || addr_err) stray++;
            if (busy) cnt++;
        end
        clear_req = 1'b0; wr_en = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0;
        checks++; if (cnt !== 128 || busy !== 1'b0) begin fails++; $display("FAIL busy_len cycles=%0d busy=%b want 128/0", cnt, busy); end
        checks++; if (stray !== 0) begin fails++; $display("FAIL busy_ignored stray=%0d want 0", stray); end
        nonzero = 0;
        for (int i = 0; i < 128; i++) begin
            do_read_a(7'(i), d, v);
            if (d !== 32'h0 || v !== 1'b1) nonzero++;
        end
        checks++; if (nonzero !== 0) begin fails++; $display("FAIL clear_all nonzero=%0d want 0", nonzero); end
    endtask

    task automatic test_reset_mid_clear();
        logic [31:0] d; logic v;
        int nonzero;
        do_write(7'd100, 4'hF, 32'hCAFEF00D);
        do_write(7'd127, 4'hF, 32'h01234567);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (40) tick();
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_sweep busy=%b want 1", busy); end
        reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_abort busy=%b want 0", busy); end
        tick();
        reset_n = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_ready busy=%b want 0", busy); end
        do_read_a(7'd100, d, v);
        checks++; if (d !== 32'h0 || v !== 1'b1) begin fails++; $display("FAIL rst_word100 data=%h valid=%b want 0/1", d, v); end
        nonzero = 0;
        for (int i = 0; i < 128; i++) begin
            do_read_a(7'(i), d, v);
            if (d !== 32'h0) nonzero++;
        end
        checks++; if (nonzero !== 0) begin fails++; $display("FAIL rst_all nonzero=%0d want 0", nonzero); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_write_first();
        test_dual_port();
        test_out_of_range();
        test_clear();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w.md
REGFILE_2R1W -- requirements
Module: regfile_2r1w

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32, word width in bits; multiple of 8.
REQ-002 SHALL have parameter LENGTH, default 128, number of words; need not be a power of two.
REQ-003 SHALL have parameter AW, default $clog2(LENGTH), address width.
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port wr_en  in  1  write request.
REQ-007 SHALL have port wr_addr  in  AW  write address.
REQ-008 SHALL have port wr_be  in  WORD_WIDTH/8  byte enables; bit i covers bits 8i+7:8i.
REQ-009 SHALL have port wr_data  in  WORD_WIDTH  write data.
REQ-010 SHALL have ports rd_en_a / rd_en_b  in  1  read requests, ports A and B.
REQ-011 SHALL have ports rd_addr_a / rd_addr_b  in  AW  read addresses.
REQ-012 SHALL have ports rd_data_a / rd_data_b  out  WORD_WIDTH  registered read data.
REQ-013 SHALL have ports rd_valid_a / rd_valid_b  out  1  one-cycle pulse, data valid.
REQ-014 SHALL have port clear_req  in  1  request to zero all words.
REQ-015 SHALL have port busy  out  1  high while clearing.
REQ-016 SHALL have port addr_err  out  1  one-cycle pulse on any out-of-range access.

Function
REQ-017 SHALL implement FSM states READY and CLEAR.
REQ-018 In READY, wr_en with wr_addr<LENGTH SHALL update only bytes with wr_be set, at the next edge.
REQ-019 In READY, rd_en_x with rd_addr_x<LENGTH SHALL drive rd_data_x and pulse rd_valid_x one cycle later (latency 1).
REQ-020 Same-cycle read and write to one address SHALL return write-first data: new bytes where wr_be set, old bytes elsewhere.
REQ-021 Ports A and B SHALL operate independently; the same address on both SHALL return identical data.
REQ-022 rd_data_x SHALL hold its last value while rd_valid_x is low.
REQ-023 Out-of-range write SHALL be dropped; out-of-range read SHALL return zero with rd_valid_x high; either SHALL pulse addr_err next cycle.
REQ-024 clear_req in READY SHALL enter CLEAR next cycle; a sweep counter SHALL zero word 0..LENGTH-1, one per cycle, then return to READY.
REQ-025 busy SHALL be high for exactly LENGTH cycles, starting the cycle after clear_req is sampled.
REQ-026 In CLEAR, wr_en and rd_en_x SHALL be ignored: no update, no rd_valid_x, no addr_err.
REQ-027 clear_req in the same cycle as wr_en SHALL win; that write SHALL be dropped. Reads sampled in that cycle SHALL complete normally.
REQ-028 clear_req while in CLEAR SHALL be ignored; the sweep SHALL NOT restart.
REQ-029 wr_be all zero SHALL leave the word unchanged and SHALL NOT raise addr_err.

Reset
REQ-030 reset_n low SHALL asynchronously zero all words, rd_data_x, rd_valid_x, addr_err, busy and the sweep counter, and SHALL force READY.
REQ-031 Reset asserted during CLEAR SHALL abort the sweep; after release the block SHALL be READY with all words zero.

Structure
REQ-032 Package regfile_pkg SHALL hold the FSM state typedef (READY, CLEAR) and the byte-width constant (8).
REQ-033 One sub-module, rf_word, SHALL hold one byte-enabled storage word with async reset and a synchronous clear input; it SHALL be instantiated LENGTH times by generate.

Verification
REQ-034 Write 0xDEADBEEF @5, be=0xF; read A @5 next cycle -> rd_data_a=0xDEADBEEF, rd_valid_a high one cycle later.
REQ-035 Word @7=0x11223344; write 0xAABBCCDD, be=0x5; same-cycle read B @7 -> rd_data_b=0x11BB33DD.
REQ-036 LENGTH=100: write @120 then read A @120 -> no update, rd_data_a=0, rd_valid_a=1, addr_err pulses once per access.
REQ-037 Fill all words; clear_req with a simultaneous wr_en @3 -> busy high exactly 128 cycles, reads ignored during busy, afterwards every word reads 0.
REQ-038 Assert reset_n low at sweep index 40 -> busy=0, READY; every word reads 0 after release.
REQ-039 Reads on A and B of the same address @9, and of different addresses @9/@10, in one cycle -> both ports return correct data with latency 1.
